// File: rtl/mips_port_pkg.sv
// Shared definitions for the MIPS memory-mapped port unit: register offsets,
// STATUS/CTRL bit positions and the output handshake state type.
package mips_port_pkg;

    localparam logic [1:0] OFF_DATA_IN  = 2'd0;
    localparam logic [1:0] OFF_STATUS   = 2'd1;
    localparam logic [1:0] OFF_DATA_OUT = 2'd2;
    localparam logic [1:0] OFF_CTRL     = 2'd3;

    localparam int ST_CHANGED_BIT  = 0;
    localparam int ST_BUSY_BIT     = 1;
    localparam int ST_OVERRUN_BIT  = 2;
    localparam int ST_IRQ_PEND_BIT = 3;

    localparam int CTRL_IRQ_EN_BIT = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } out_state_e;

endpackage

// File: rtl/mips_port_io_sync.sv
// Two-flop synchroniser for the external pins plus a previous-value flop;
// change is high while the synchronised value differs from the one before it.
module port_in_sync #(
    parameter int IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] pin_in,
    output logic [IN_WIDTH-1:0] sync_data,
    output logic                change
);

    logic [IN_WIDTH-1:0] meta_q, meta_d;
    logic [IN_WIDTH-1:0] sync_q, sync_d;
    logic [IN_WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = pin_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_data = sync_q;
    assign change    = (sync_q != prev_q);

endmodule

// File: rtl/mips_port_io.sv
// Memory-mapped I/O port on the MIPS data bus: DATA_IN/STATUS/DATA_OUT/CTRL window.
// Optional change interrupt enabled by defining PORT_IRQ_EN.
module mips_port_io
    import mips_port_pkg::*;
#(
    parameter int          IN_WIDTH  = 8,
    parameter int          OUT_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Address,
    input  logic [31:0]          WriteData,
    input  logic                 MemWrite,
    input  logic                 MemRead,
    output logic [31:0]          ReadData,
    input  logic [IN_WIDTH-1:0]  PortIn,
    output logic [OUT_WIDTH-1:0] PortOut,
    output logic                 PortOutValid,
    input  logic                 PortOutReady,
    output logic                 Irq
);

    logic [IN_WIDTH-1:0] sync_data;
    logic                in_change;

    port_in_sync #(.IN_WIDTH(IN_WIDTH)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .pin_in    (PortIn),
        .sync_data (sync_data),
        .change    (in_change)
    );

    logic       sel;
    logic [1:0] off;
    logic       wr_status, wr_data_out, wr_ctrl;

    assign sel         = (Address[31:4] == BASE_ADDR[31:4]);
    assign off         = Address[3:2];
    assign wr_status   = MemWrite & sel & (off == OFF_STATUS);
    assign wr_data_out = MemWrite & sel & (off == OFF_DATA_OUT);
    assign wr_ctrl     = MemWrite & sel & (off == OFF_CTRL);

    logic unused_bits;
    assign unused_bits = ^{Address[1:0], wr_ctrl, WriteData};

    out_state_e           state_q, state_d;
    logic [OUT_WIDTH-1:0] port_out_q, port_out_d;
    logic                 changed_q, changed_d;
    logic                 overrun_q, overrun_d;
    logic [31:0]          read_data_q, read_data_d;
    logic                 irq_en;
    logic                 irq_pend;

`ifdef PORT_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_ctrl) begin
            irq_en_d = WriteData[CTRL_IRQ_EN_BIT];
        end
        irq_d = irq_pend;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en = irq_en_q;
    assign Irq    = irq_q;
`else
    assign irq_en = 1'b0;
    assign Irq    = 1'b0;
`endif

    assign irq_pend = changed_q & irq_en;

    logic [31:0] status_val;
    logic [31:0] ctrl_val;

    always_comb begin
        status_val                  = '0;
        status_val[ST_CHANGED_BIT]  = changed_q;
        status_val[ST_BUSY_BIT]     = (state_q == ST_VALID);
        status_val[ST_OVERRUN_BIT]  = overrun_q;
        status_val[ST_IRQ_PEND_BIT] = irq_pend;
        ctrl_val                    = '0;
        ctrl_val[CTRL_IRQ_EN_BIT]   = irq_en;
    end

    // A new edge on the pins outranks a simultaneous W1C so no change is lost.
    always_comb begin
        changed_d = changed_q;
        if (wr_status && WriteData[ST_CHANGED_BIT]) begin
            changed_d = 1'b0;
        end
        if (in_change) begin
            changed_d = 1'b1;
        end
    end

    // Stores are accepted only from IDLE; a store landing on the handshake cycle is still dropped.
    always_comb begin
        state_d    = state_q;
        port_out_d = port_out_q;
        overrun_d  = overrun_q;
        if (wr_status && WriteData[ST_OVERRUN_BIT]) begin
            overrun_d = 1'b0;
        end
        if (state_q == ST_IDLE) begin
            if (wr_data_out) begin
                port_out_d = WriteData[OUT_WIDTH-1:0];
                state_d    = ST_VALID;
            end
        end else begin
            if (wr_data_out) begin
                overrun_d = 1'b1;
            end
            if (PortOutReady) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        read_data_d = read_data_q;
        if (MemRead) begin
            if (!sel) begin
                read_data_d = '0;
            end else begin
                case (off)
                    OFF_DATA_IN:  read_data_d = 32'(sync_data);
                    OFF_STATUS:   read_data_d = status_val;
                    OFF_DATA_OUT: read_data_d = 32'(port_out_q);
                    default:      read_data_d = ctrl_val;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            port_out_q  <= '0;
            changed_q   <= 1'b0;
            overrun_q   <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            port_out_q  <= port_out_d;
            changed_q   <= changed_d;
            overrun_q   <= overrun_d;
            read_data_q <= read_data_d;
        end
    end

    assign ReadData     = read_data_q;
    assign PortOut      = port_out_q;
    assign PortOutValid = (state_q == ST_VALID);

endmodule
